led_chase_ctrl: RTL and testbench
=================================

Name: led_chase_ctrl

Overview:
Sequencer for the one-hot LED chase ring. It owns an N-bit one-hot ring register and decides when it shifts and in which direction: rotate left, rotate right, bounce or hold. A programmable prescaler sets the step rate, a pass counter ends the run after a set number of passes, and start/stop pulses control it. It sits between the board clock/reset and the LED pins, or a downstream LED driver.

Parameters:
N, 4, ring width in LEDs; must be >= 2.
DIV_W, 24, width of the step-period divider.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous, active-low reset
start  input  1  pulse; begin a run (sampled only in IDLE)
stop  input  1  pulse; abort a run (sampled only in RUN)
hold  input  1  level; freezes the prescaler while high
mode  input  2  00 rotate right, 01 rotate left, 10 bounce, 11 hold pattern
div  input  DIV_W  step period in clocks minus one
cycles  input  8  passes before auto-stop; 0 = run forever
led  output  N  LED pattern (registered)
busy  output  1  high while in RUN
step  output  1  one-cycle pulse on every step
done  output  1  one-cycle pulse when the pass count completes
duty  input  4  present only with LED_CHASE_DIM_EN

Behaviour:
- Reset (clk edge with rst_n=0), also mid-run:
  - state IDLE; led = 1 (bit0 set); busy = 0, step = 0, done = 0.
  - Prescaler, pass counter and step-in-pass counter = 0; bounce direction = left.
- Direction definitions:
  - Left = toward MSB: led <= {led[N-2:0], led[N-1]}.
  - Right = toward LSB: led <= {led[0], led[N-1:1]}.
- States: IDLE and RUN.
- IDLE -> RUN on the edge where start=1 and stop=0:
  - mode, div and cycles are latched; later changes to them have no effect until the next start.
  - led = 1, prescaler = 0, counters = 0, bounce direction = left, busy = 1 from that edge.
- RUN:
  - Prescaler increments each cycle while hold=0. While hold=1 it is frozen and no step occurs.
  - When prescaler == latched div and hold=0: prescaler <= 0, led shifts, and step is high for one cycle aligned with the new led value.
  - If start is accepted at edge k, with hold=0 the first step lands at edge k+div+1 and then every div+1 cycles. div=0 gives a step every cycle.
- Per-mode step action:
  - 00: shift right.
  - 01: shift left.
  - 10: shift in the current direction. The direction reverses when the new led reaches bit N-1 (becomes right) or bit0 (becomes left), so there is no dwell at the ends.
  - 11: led unchanged; step still pulses.
- Pass length: N steps for modes 00, 01 and 11; 2*(N-1) steps for mode 10. Every pass starts and ends with led = 1.
- Completion: on the step that completes a pass, the pass counter increments.
  - If cycles != 0 and the new count == cycles: same edge sets state IDLE, busy = 0, done = 1 for one cycle.
  - led stays at 1 after completion.
  - Pass counter is 8 bits; with cycles=0 it wraps silently.
- Abort: stop=1 in RUN -> IDLE on that edge, busy = 0, no done, no step that cycle, led frozen at its current value. stop has priority over a coincident step or completion.
- Ignored inputs:
  - start while in RUN.
  - stop while in IDLE.
  - start and stop together in IDLE: stop wins, block stays IDLE.
- step and done are never high in IDLE except on the completion edge's output cycle.

Optional Feature:
- Macro LED_CHASE_DIM_EN.
- Defined:
  - Adds the duty input and a free-running 4-bit PWM counter, reset to 0 and counting in all states.
  - led = pattern & {N{pwm_cnt < duty}}: duty=0 gives all LEDs off; duty=15 gives on 15 of 16 cycles.
  - The internal ring pattern, step, done and busy are unaffected by the PWM.
- Undefined: no duty port, no PWM counter; led = ring pattern directly.

Test Plan:
- Reset, then start with mode=01, div=2, cycles=1, N=4 -> step every 3 clocks; led 0010,0100,1000,0001; done pulses with the 4th step; busy falls on the same edge.
- mode=10, div=0, cycles=2 -> led 0010,0100,1000,0100,0010,0001 repeated twice (12 steps); done on step 12.
- mode=00, div=0, cycles=0; assert stop after 5 steps -> led 0001,1000,0100,0010,0001,1000 then frozen at 1000; busy=0; done never pulses.
- mode=01, div=3; hold=1 for 10 cycles mid-period -> step gap stretched by exactly 10 cycles; no steps while hold=1.
- start and stop in the same IDLE cycle -> stays IDLE, busy=0. start pulsed during RUN -> no restart; step phase unchanged.
- rst_n=0 mid-run, mode=10 -> next edge led=0001, busy=0; after restart, bounce initially moves left. With LED_CHASE_DIM_EN: duty=4 -> led nonzero exactly 4 of every 16 cycles.

Source files
------------

// File: rtl/led_chase_ctrl_if.sv
// Control/status bundle for the LED chase sequencer.
// Optional duty input is present only when LED_CHASE_DIM_EN is defined.
interface led_chase_ctrl_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned DIV_W = 24
);
  logic             start;
  logic             stop;
  logic             hold;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [7:0]       cycles;
`ifdef LED_CHASE_DIM_EN
  logic [3:0]       duty;
`endif
  logic [N-1:0]     led;
  logic             busy;
  logic             step;
  logic             done;

`ifdef LED_CHASE_DIM_EN
  modport master (output start, stop, hold, mode, div, cycles, duty,
                  input  led, busy, step, done);
  modport slave  (input  start, stop, hold, mode, div, cycles, duty,
                  output led, busy, step, done);
`else
  modport master (output start, stop, hold, mode, div, cycles,
                  input  led, busy, step, done);
  modport slave  (input  start, stop, hold, mode, div, cycles,
                  output led, busy, step, done);
`endif
endinterface

// File: rtl/led_chase_ctrl.sv
// One-hot LED chase ring sequencer: rotate right/left, bounce or hold,
// programmable step period, pass-count auto stop, start/stop control.
// Optional PWM dimming enabled by defining LED_CHASE_DIM_EN.
module led_chase_ctrl #(
  parameter int unsigned N     = 4,
  parameter int unsigned DIV_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_chase_ctrl_if.slave      bus
);

  localparam int unsigned SIP_W = $clog2(2 * N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     ring_q, ring_d;
  logic [N-1:0]     led_q, led_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       pass_q, pass_d;
  logic [7:0]       cycles_q, cycles_d;
  logic [SIP_W-1:0] sip_q, sip_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;     // 1 = left (toward MSB)
  logic             busy_q, busy_d;
  logic             step_q, step_d;
  logic             done_q, done_d;

  logic [N-1:0]     rot_l, rot_r, next_ring;
  logic             next_dir;
  logic [SIP_W-1:0] pass_len;
  logic [SIP_W-1:0] sip_inc;
  logic [7:0]       pass_inc;

`ifdef LED_CHASE_DIM_EN
  logic [3:0] pwm_q, pwm_d;
`endif

  // Candidate next ring pattern and bounce direction for a step.
  always_comb begin
    rot_l     = {ring_q[N-2:0], ring_q[N-1]};
    rot_r     = {ring_q[0], ring_q[N-1:1]};
    next_ring = ring_q;
    next_dir  = dir_q;
    pass_len  = SIP_W'(N);
    case (mode_q)
      2'b00: next_ring = rot_r;
      2'b01: next_ring = rot_l;
      2'b10: begin
        next_ring = dir_q ? rot_l : rot_r;
        pass_len  = SIP_W'(2 * (N - 1));
        if (next_ring[N-1])  next_dir = 1'b0;
        else if (next_ring[0]) next_dir = 1'b1;
      end
      default: next_ring = ring_q;
    endcase
    sip_inc  = sip_q + SIP_W'(1);
    pass_inc = pass_q + 8'd1;
  end

  // Next-state, counters and output pulses.
  always_comb begin
    state_d  = state_q;
    ring_d   = ring_q;
    pre_d    = pre_q;
    div_d    = div_q;
    pass_d   = pass_q;
    cycles_d = cycles_q;
    sip_d    = sip_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d  = RUN;
          mode_d   = bus.mode;
          div_d    = bus.div;
          cycles_d = bus.cycles;
          ring_d   = N'(1);
          pre_d    = '0;
          pass_d   = '0;
          sip_d    = '0;
          dir_d    = 1'b1;
        end
      end
      default: begin
        if (bus.stop) begin
          // Abort wins over any step or completion on this edge.
          state_d = IDLE;
        end else if (!bus.hold) begin
          if (pre_q == div_q) begin
            pre_d  = '0;
            ring_d = next_ring;
            dir_d  = next_dir;
            step_d = 1'b1;
            if (sip_inc == pass_len) begin
              sip_d  = '0;
              pass_d = pass_inc;
              if ((cycles_q != 8'd0) && (pass_inc == cycles_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              sip_d = sip_inc;
            end
          end else begin
            pre_d = pre_q + DIV_W'(1);
          end
        end
      end
    endcase
    busy_d = (state_d == RUN);
  end

`ifdef LED_CHASE_DIM_EN
  // Free-running PWM gate applied only to the pin-level pattern.
  always_comb begin
    pwm_d = pwm_q + 4'd1;
    led_d = ring_d & {N{pwm_d < bus.duty}};
  end
`else
  // Pin-level pattern is the ring itself.
  always_comb begin
    led_d = ring_d;
  end
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ring_q   <= N'(1);
      led_q    <= N'(1);
      pre_q    <= '0;
      div_q    <= '0;
      pass_q   <= '0;
      cycles_q <= '0;
      sip_q    <= '0;
      mode_q   <= '0;
      dir_q    <= 1'b1;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ring_q   <= ring_d;
      led_q    <= led_d;
      pre_q    <= pre_d;
      div_q    <= div_d;
      pass_q   <= pass_d;
      cycles_q <= cycles_d;
      sip_q    <= sip_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
    end
  end

`ifdef LED_CHASE_DIM_EN
  // PWM counter runs in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end
`endif

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.step = step_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_led_chase_ctrl.sv
// Directed bench for led_chase_ctrl (N=4) with hand-computed expectations.
module tb_led_chase_ctrl;
  localparam int unsigned N     = 4;
  localparam int unsigned DIV_W = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  led_chase_ctrl_if #(.N(N), .DIV_W(DIV_W)) bus ();
  led_chase_ctrl #(.N(N), .DIV_W(DIV_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait gap cycles; only the last one carries a step with the given led/done.
  task automatic expect_step(input string tag, input logic [3:0] exp_led, input int gap,
                             input logic exp_done);
    for (int i = 0; i < gap - 1; i++) begin
      tick();
      check_eq({tag, " gap step"}, 32'(bus.step), 32'd0);
    end
    tick();
    check_eq({tag, " step"}, 32'(bus.step), 32'd1);
    check_eq({tag, " led"},  32'(bus.led),  32'(exp_led));
    check_eq({tag, " done"}, 32'(bus.done), 32'(exp_done));
  endtask

  task automatic start_run(input logic [1:0] m, input logic [DIV_W-1:0] d, input logic [7:0] c);
    bus.mode   = m;
    bus.div    = d;
    bus.cycles = c;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  logic [3:0] seq_l [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] seq_b [6]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] seq_r [5]  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

  initial begin
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.hold   = 1'b0;
    bus.mode   = 2'b00;
    bus.div    = '0;
    bus.cycles = 8'd0;
`ifdef LED_CHASE_DIM_EN
    bus.duty   = 4'd15;
`endif

    // Reset state
    tick(); tick();
    check_eq("rst led",  32'(bus.led),  32'd1);
    check_eq("rst busy", 32'(bus.busy), 32'd0);
    check_eq("rst step", 32'(bus.step), 32'd0);
    check_eq("rst done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Rotate left, div=2, one pass; mode change after start is ignored
    start_run(2'b01, 24'd2, 8'd1);
    bus.mode = 2'b00;
    check_eq("rl busy", 32'(bus.busy), 32'd1);
    check_eq("rl led0", 32'(bus.led),  32'd1);
    for (int i = 0; i < 4; i++) expect_step("rl", seq_l[i], 3, (i == 3));
    check_eq("rl busy end", 32'(bus.busy), 32'd0);
    tick();
    check_eq("rl done once", 32'(bus.done), 32'd0);
    check_eq("rl idle step", 32'(bus.step), 32'd0);
    check_eq("rl led hold",  32'(bus.led),  32'd1);

    // Bounce, div=0, two passes
    start_run(2'b10, 24'd0, 8'd2);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 6; i++) expect_step("bn", seq_b[i], 1, (p == 1 && i == 5));
    check_eq("bn busy end", 32'(bus.busy), 32'd0);
    tick();
    check_eq("bn done once", 32'(bus.done), 32'd0);

    // Rotate right forever, abort after 5 steps
    start_run(2'b00, 24'd0, 8'd0);
    for (int i = 0; i < 5; i++) expect_step("rr", seq_r[i], 1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_eq("ab step", 32'(bus.step), 32'd0);
    check_eq("ab busy", 32'(bus.busy), 32'd0);
    check_eq("ab done", 32'(bus.done), 32'd0);
    check_eq("ab led",  32'(bus.led),  32'b1000);
    tick(); tick();
    check_eq("ab led frozen", 32'(bus.led),  32'b1000);
    check_eq("ab no done",    32'(bus.done), 32'd0);

    // Hold mid-period stretches the gap by exactly 10 cycles
    start_run(2'b01, 24'd3, 8'd0);
    tick(); tick();
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold no step", 32'(bus.step), 32'd0);
    end
    bus.hold = 1'b0;
    expect_step("hold1", 4'b0010, 2, 1'b0);
    expect_step("hold2", 4'b0100, 4, 1'b0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check_eq("hold stop busy", 32'(bus.busy), 32'd0);

    // start+stop together in IDLE stays idle
    bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 2'b01; bus.div = 24'd1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check_eq("ss busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("ss step", 32'(bus.step), 32'd0);

    // start during RUN does not restart or re-phase
    start_run(2'b01, 24'd1, 8'd0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("rs step",  32'(bus.step), 32'd1);
    check_eq("rs led",   32'(bus.led),  32'b0010);
    expect_step("rs next", 4'b0100, 2, 1'b0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

    // Reset mid-run in bounce, then bounce restarts heading left
    start_run(2'b10, 24'd0, 8'd0);
    for (int i = 0; i < 3; i++) expect_step("mr", seq_b[i], 1, 1'b0);
    rst_n = 1'b0;
    tick();
    check_eq("mr led",  32'(bus.led),  32'd1);
    check_eq("mr busy", 32'(bus.busy), 32'd0);
    check_eq("mr step", 32'(bus.step), 32'd0);
    rst_n = 1'b1;
    start_run(2'b10, 24'd0, 8'd0);
    expect_step("mr left", 4'b0010, 1, 1'b0);
    expect_step("mr left2", 4'b0100, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
